// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } state_e;

  // Cycles between a column change and rows_s reflecting that column.
  localparam int unsigned SYNC_LAT = 2;

  // Key codes indexed by {row, col}; entry 0 sits in the low nibble.
  localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] w_idx;
    w_idx = {row, col, 2'b00};
    return KEY_TABLE[w_idx +: 4];
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] w_sel;
    w_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) w_sel = 2'(i);
    end
    return w_sel;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset and a configurable reset value.
module sync2 #(
  parameter int unsigned        WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one pulse per accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 1000,
  parameter int unsigned DB_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned MAX_CYC = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_MASK = CNT_W'(SYNC_LAT);

  logic [3:0]       w_rows_s;
  logic             w_row_low;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [3:0]       r_col_n;
  logic             r_key_valid;
  logic [3:0]       r_key_code;

  sync2 #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (row_n),
    .o_q   (w_rows_s)
  );

  assign w_row_low = ~w_rows_s[r_row];

  // The column only moves in SCAN or when a release completes, so it stays frozen on the pressed key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_col_n     <= 4'b1110;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if ((r_cnt >= SYNC_MASK) && (w_rows_s != 4'b1111)) begin
            r_row   <= first_low(w_rows_s);
            r_cnt   <= '0;
            r_state <= ST_PRESS_DB;
          end else if (r_cnt == SCAN_LAST) begin
            r_col   <= r_col + 2'd1;
            r_col_n <= col_drive(r_col + 2'd1);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRESS_DB: begin
          if (!w_row_low) begin
            r_cnt   <= '0;
            r_state <= ST_SCAN;
          end else if (r_cnt == DB_LAST) begin
            r_cnt       <= '0;
            r_state     <= ST_HELD;
            r_key_valid <= 1'b1;
            r_key_code  <= key_lookup(r_row, r_col);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!w_row_low) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (w_row_low) begin
            r_cnt   <= '0;
            r_state <= ST_HELD;
          end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_col   <= r_col + 2'd1;
            r_col_n <= col_drive(r_col + 2'd1);
            r_state <= ST_SCAN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_n     = r_col_n;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives row_n from col_n.
module tb_keypad_scanner;

  localparam int SCAN = 8;
  localparam int DB   = 16;
  localparam int SYNC = 2;

  localparam logic [3:0] KMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  typedef struct {
    logic [3:0] code;
    logic [3:0] col;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;

  logic       pressed [4][4];
  exp_t       exp_q [$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] last_code = 4'h0;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES (SCAN),
    .DB_CYCLES   (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // A row reads low when any pressed key on it sits on a driven (low) column.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic logic [3:0] colpat(input int c);
    logic [3:0] v;
    v = 4'b1111;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic wait_col_start(input int c);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = col_n;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (col_n == colpat(c) && prev != colpat(c)) found = 1'b1;
      prev = col_n;
    end
    check("col_start_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int max, output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 1; i <= max && !ok; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        n = i;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Monitor: pops an expectation on every pulse; checks column shape and key_code hold.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      last_code  = 4'h0;
      prev_valid = 1'b0;
    end else begin
      check("col_one_low", 32'($countones(~col_n)), 32'd1);
      if (key_valid) begin
        check("valid_back_to_back", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=code %0h required=no pulse t=%0t", key_code, $time);
        end else begin
          e = exp_q.pop_front();
          check("key_code", 32'(key_code), 32'(e.code));
          check("col_at_pulse", 32'(col_n), 32'(e.col));
          last_code = e.code;
        end
      end else begin
        check("key_code_hold", 32'(key_code), 32'(last_code));
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    bit found;
    exp_t e;

    release_all();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'h0000000e);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    reset = 1'b1;
    repeat (50) @(negedge clk);

    // Clean press: row1 on col2 -> 6, column frozen for the whole press.
    wait_col_start(2);
    pressed[1][2] = 1'b1;
    e.code = KMAP[1][2]; e.col = colpat(2); exp_q.push_back(e);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("s1_col_frozen", 32'(col_n), 32'(colpat(2)));
      if (key_valid) pulses++;
    end
    check("s1_pulse_count", 32'(pulses), 32'd1);
    release_all();
    repeat (40) @(negedge clk);

    // Short bounce on row0/col0: no pulse, scan restarts on col0.
    wait_col_start(0);
    pressed[0][0] = 1'b1;
    repeat (10) @(negedge clk);
    pressed[0][0] = 1'b0;
    repeat (5) @(negedge clk);
    check("s2_col_held_after_bounce", 32'(col_n), 32'(colpat(0)));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_n == colpat(1)) found = 1'b1;
    end
    check("s2_scan_resumes", 32'(found), 32'd1);
    repeat (20) @(negedge clk);

    // Long hold row3/col1 -> 0, then a bouncy release with no further pulse.
    wait_col_start(1);
    pressed[3][1] = 1'b1;
    e.code = KMAP[3][1]; e.col = colpat(1); exp_q.push_back(e);
    repeat (300) @(negedge clk);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      pressed[3][1] = (k % 2 == 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (key_valid) pulses++;
      end
    end
    pressed[3][1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check("s3_release_bounce_pulses", 32'(pulses), 32'd0);

    // Rows 0 and 2 on col3 together -> A; a later row1/col0 press is ignored.
    wait_col_start(3);
    pressed[0][3] = 1'b1;
    pressed[2][3] = 1'b1;
    e.code = KMAP[0][3]; e.col = colpat(3); exp_q.push_back(e);
    wait_valid("s4_pulse_timeout", 100, n);
    pressed[1][0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check("s4_no_rollover", 32'(pulses), 32'd0);
    check("s4_col_frozen", 32'(col_n), 32'(colpat(3)));
    release_all();
    repeat (40) @(negedge clk);

    // Random single presses: long ones must be accepted once, short glitches never.
    for (int it = 0; it < 14; it++) begin
      int r;
      int c;
      int hold;
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        hold = int'($urandom_range(60, 120));
        e.code = KMAP[r][c]; e.col = colpat(c); exp_q.push_back(e);
      end else begin
        hold = int'($urandom_range(1, 8));
      end
      pressed[r][c] = 1'b1;
      repeat (hold) @(negedge clk);
      pressed[r][c] = 1'b0;
      repeat (int'($urandom_range(40, 55))) @(negedge clk);
    end
    check("random_all_accepted", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while HELD, then re-debounce of the still-held key.
    wait_col_start(1);
    pressed[2][1] = 1'b1;
    e.code = KMAP[2][1]; e.col = colpat(1); exp_q.push_back(e);
    wait_valid("s5_pulse_timeout", 100, n);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("s5_async_col_n", 32'(col_n), 32'h0000000e);
    check("s5_async_key_valid", 32'(key_valid), 32'd0);
    check("s5_async_key_code", 32'(key_code), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    e.code = KMAP[2][1]; e.col = colpat(1); exp_q.push_back(e);
    wait_valid("s5_reaccept_timeout", 200, n);
    check("s5_full_debounce_after_reset", 32'(n >= DB + SYNC), 32'd1);
    release_all();
    repeat (40) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 1000, clocks each column is driven in SCAN (minimum 4).
REQ-002 SHALL have parameter DB_CYCLES, default 50000, press/release debounce window in clocks (minimum 4).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_n  input  4  raw keypad rows, active-low with external pull-ups, asynchronous to clk.
REQ-006 SHALL have port col_n  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse per debounced key press.
REQ-008 SHALL have port key_code  output  4  hex code of the last accepted key; holds between pulses.

Function
REQ-009 SHALL pass row_n through a 2-flop synchronizer (reset value 4'b1111) before any use; the result is called rows_s.
REQ-010 SHALL implement states SCAN, PRESS_DB, HELD and RELEASE_DB, all registered.
REQ-011 SCAN: scan counter increments each cycle; at SCAN_CYCLES-1 the column index advances (3 wraps to 0) and the counter clears.
REQ-012 SCAN: rows_s SHALL be ignored while scan counter < 2, masking synchronizer latency after a column change.
REQ-013 SCAN with counter >= 2 and any rows_s bit low: latch the lowest-index low row and the current column, clear the counter, go to PRESS_DB; the column is frozen.
REQ-014 PRESS_DB: counter increments while the latched row stays low; at DB_CYCLES-1 go to HELD.
REQ-015 PRESS_DB: if the latched row reads high, clear the counter and return to SCAN on the same column with the scan counter at 0, with no key_valid.
REQ-016 On the PRESS_DB to HELD transition: key_valid is high for exactly the first HELD cycle, and key_code is updated in the same cycle.
REQ-017 key_code mapping by [row][col] SHALL be: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E,0,F,D.
REQ-018 HELD: remain while the latched row is low; other rows and columns are ignored (no rollover); on latched row high, clear the counter and go to RELEASE_DB.
REQ-019 RELEASE_DB: counter increments while the latched row stays high; at DB_CYCLES-1 go to SCAN, advance the column and clear the scan counter.
REQ-020 RELEASE_DB: if the latched row reads low, return to HELD with no new key_valid.
REQ-021 Counter widths SHALL be $clog2 of the larger of SCAN_CYCLES and DB_CYCLES; counters SHALL never wrap past their terminal value.
REQ-022 key_valid SHALL never be high in two consecutive cycles.

Reset
REQ-023 While reset is low, every flop SHALL clear asynchronously and immediately, regardless of state.
REQ-024 Reset values: state SCAN, column index 0, col_n 4'b1110, key_valid 0, key_code 4'h0, counters 0, synchronizer 4'b1111.
REQ-025 After reset deasserts, operation SHALL start on the first rising edge; a key held through reset SHALL be re-debounced from SCAN.

Structure
REQ-026 A shared package keypad_pkg SHALL hold the state enum, the 16-entry key-code table and the synchronizer-latency constant (2).
REQ-027 The synchronizer SHALL be the sub-module sync2, parameterised by width, with asynchronous active-low reset and configurable reset value.
REQ-028 The debounce and scan counters SHALL be inline; there SHALL be no other sub-modules.

Verification (bench: SCAN_CYCLES=8, DB_CYCLES=16)
REQ-029 Clean press: row1 low while col2 is driven, held 100 cycles -> exactly one key_valid pulse with key_code=4'h6, and col_n stays 4'b1011 throughout the press.
REQ-030 Short bounce: row0 low for 10 cycles on col0, then high -> no key_valid, and scanning resumes from col0.
REQ-031 Long hold and bouncy release: row3 on col1 held 300 cycles, then toggled every 5 cycles for 30 cycles, then high -> exactly one pulse with key_code=4'h0, and no pulse during the release bounce.
REQ-032 Multiple keys: rows 0 and 2 low on col3 simultaneously -> key_code=4'hA; pressing row1 on col0 during HELD is ignored.
REQ-033 Async reset in HELD: reset low mid-cycle -> col_n=4'b1110, key_valid=0 and key_code=0 before the next clock edge; the held key is re-accepted only after a full debounce window.
